// File: rtl/sha1_pkg.sv
// rtl/sha1_pkg.sv - shared types and constants for the SHA-1 multi-block sequencer
package sha1_pkg;

  localparam int BLOCK_W  = 512;
  localparam int DIGEST_W = 160;
  localparam int WORD_W   = 32;

  localparam logic [WORD_W-1:0] SHA1_IV [5] = '{
    32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BLK,
    S_LAUNCH,
    S_RUN,
    S_DONE
  } seq_state_t;

  // H0 lands in the most significant word, matching the core_state/digest layout.
  function automatic logic [DIGEST_W-1:0] sha1_iv_vec();
    return {SHA1_IV[0], SHA1_IV[1], SHA1_IV[2], SHA1_IV[3], SHA1_IV[4]};
  endfunction

endpackage

// File: rtl/sha1_chain_adder.sv
// rtl/sha1_chain_adder.sv - five parallel mod-2^32 adds folding a core result into H0..H4
module sha1_chain_adder
  import sha1_pkg::*;
(
  input  logic [DIGEST_W-1:0] h,
  input  logic [DIGEST_W-1:0] result,
  output logic [DIGEST_W-1:0] sum
);

  for (genvar i = 0; i < 5; i++) begin : g_word
    assign sum[i*WORD_W +: WORD_W] = h[i*WORD_W +: WORD_W] + result[i*WORD_W +: WORD_W];
  end

endmodule

// File: rtl/sha1_multiblock_sequencer.sv
// rtl/sha1_multiblock_sequencer.sv - feeds pre-padded blocks through one SHA-1 core and chains H
module sha1_multiblock_sequencer
  import sha1_pkg::*;
#(
  parameter  int MAX_BLOCKS   = 255,
  parameter  int CORE_TIMEOUT = 100,
  localparam int CNT_W        = $clog2(MAX_BLOCKS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                msg_start,
  input  logic                blk_valid,
  output logic                blk_ready,
  input  logic [BLOCK_W-1:0]  blk_data,
  input  logic                blk_last,
  output logic                core_start,
  output logic [BLOCK_W-1:0]  core_block,
  output logic [DIGEST_W-1:0] core_state,
  input  logic                core_done,
  input  logic [DIGEST_W-1:0] core_result,
  output logic                digest_valid,
  output logic [DIGEST_W-1:0] digest,
  input  logic                digest_ack,
  output logic                busy,
  output logic                error,
  output logic [CNT_W-1:0]    blk_count
);

  localparam int TMR_W = $clog2(CORE_TIMEOUT + 1);

  seq_state_t          state, state_next;
  logic [DIGEST_W-1:0] h_q;
  logic [DIGEST_W-1:0] h_sum;
  logic [TMR_W-1:0]    timer;
  logic                last_q;
  logic                start_msg, accept, overflow, timeout_hit;

  sha1_chain_adder u_chain_adder (
    .h      (h_q),
    .result (core_result),
    .sum    (h_sum)
  );

  assign core_state = h_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_msg   = 1'b0;
    accept      = 1'b0;
    overflow    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (msg_start) begin
          start_msg  = 1'b1;
          state_next = S_WAIT_BLK;
        end
      end
      S_DONE: begin
        if (msg_start) begin
          start_msg  = 1'b1;
          state_next = S_WAIT_BLK;
        end else if (digest_ack) begin
          state_next = S_IDLE;
        end
      end
      S_WAIT_BLK: begin
        if (blk_valid && blk_ready) begin
          accept     = 1'b1;
          overflow   = !blk_last && (blk_count == CNT_W'(MAX_BLOCKS));
          state_next = overflow ? S_IDLE : S_LAUNCH;
        end
      end
      S_LAUNCH: state_next = S_RUN;
      S_RUN: begin
        // A done arriving on the final counted cycle still completes normally.
        if (core_done) begin
          state_next = last_q ? S_DONE : S_WAIT_BLK;
        end else if (timer == TMR_W'(CORE_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_next  = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_ready    <= 1'b0;
      core_start   <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
      digest_valid <= 1'b0;
      digest       <= '0;
      core_block   <= '0;
      blk_count    <= '0;
      h_q          <= sha1_iv_vec();
      timer        <= '0;
      last_q       <= 1'b0;
    end else begin
      blk_ready  <= (state_next == S_WAIT_BLK);
      core_start <= (state_next == S_LAUNCH);
      busy       <= (state_next inside {S_WAIT_BLK, S_LAUNCH, S_RUN});

      if (start_msg) begin
        h_q          <= sha1_iv_vec();
        blk_count    <= '0;
        error        <= 1'b0;
        digest_valid <= 1'b0;
      end else if (state == S_DONE && digest_ack) begin
        digest_valid <= 1'b0;
      end

      if (accept) begin
        // Count saturates so a final block arriving as block MAX_BLOCKS+1 is still taken.
        if (blk_count != CNT_W'(MAX_BLOCKS)) blk_count <= blk_count + 1'b1;
        timer <= '0;
        if (overflow) begin
          error <= 1'b1;
        end else begin
          core_block <= blk_data;
          last_q     <= blk_last;
        end
      end

      if (state == S_LAUNCH || state == S_RUN) timer <= timer + 1'b1;

      if (state == S_RUN && core_done) begin
        h_q <= h_sum;
        if (last_q) begin
          digest       <= h_sum;
          digest_valid <= 1'b1;
        end
      end

      if (timeout_hit) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sha1_multiblock_sequencer.sv
// tb/tb_sha1_multiblock_sequencer.sv - self-checking bench with a behavioural SHA-1 core and reference
module tb_sha1_multiblock_sequencer;

  localparam int MAXB = 255;
  localparam int TMO  = 100;
  localparam logic [159:0] IV_TB  = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  localparam logic [159:0] ABC_D  = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] TWO_D  = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         msg_start = 1'b0;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         blk_last = 1'b0;
  logic         core_start;
  logic [511:0] core_block;
  logic [159:0] core_state;
  logic         core_done = 1'b0;
  logic [159:0] core_result = '0;
  logic         digest_valid;
  logic [159:0] digest;
  logic         digest_ack = 1'b0;
  logic         busy;
  logic         error;
  logic [7:0]   blk_count;

  sha1_multiblock_sequencer #(.MAX_BLOCKS(MAXB), .CORE_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .msg_start(msg_start), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
    .core_start(core_start), .core_block(core_block), .core_state(core_state),
    .core_done(core_done), .core_result(core_result), .digest_valid(digest_valid),
    .digest(digest), .digest_ack(digest_ack), .busy(busy), .error(error),
    .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] sha1_rounds(input logic [511:0] blk, input logic [159:0] st);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t, x;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      x    = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {x[30:0], x[31]};
    end
    {a, b, c, d, e} = st;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {a, b, c, d, e};
  endfunction

  function automatic logic [159:0] add5(input logic [159:0] x, input logic [159:0] y);
    logic [159:0] s;
    for (int i = 0; i < 5; i++) s[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
    return s;
  endfunction

  // Behavioural core: latency counted from the core_start cycle; 0 means never answer.
  int           core_lat = 1;
  int           core_cnt = 0;
  int           starts = 0;
  int           start_cyc = 0;
  logic [159:0] core_res = '0;
  always @(negedge clk) begin
    core_done = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        core_done   = 1'b1;
        core_result = core_res;
      end
    end
    if (core_start) begin
      starts++;
      start_cyc = cyc;
      core_res  = sha1_rounds(core_block, core_state);
      core_cnt  = core_lat;
    end
  end

  typedef struct {
    int           nblk;
    int           lat;
    bit           mid_start;
    bit           hold;
    bit           ack_start;
    logic [159:0] exp;
  } vec_t;

  vec_t         tab [7];
  logic [511:0] blk_tab [7][4];

  function automatic logic [159:0] sha1_ref(input int e);
    logic [159:0] h = IV_TB;
    for (int b = 0; b < tab[e].nblk; b++) h = add5(h, sha1_rounds(blk_tab[e][b], h));
    return h;
  endfunction

  task automatic pulse_start();
    msg_start = 1'b1;
    @(negedge clk);
    msg_start = 1'b0;
  endtask

  task automatic send_block(input logic [511:0] d, input bit last, input bit hold);
    int w = 0;
    blk_data  = d;
    blk_last  = last;
    blk_valid = 1'b1;
    while (!blk_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("blk_ready_wait", 512'(blk_ready), 512'(1));
    @(negedge clk);
    if (!hold) blk_valid = 1'b0;
  endtask

  task automatic run_msg(input int e);
    int s0;
    int w = 0;
    bit hold_bad = 1'b0;
    pulse_start();
    check("start_clear", {digest_valid, error, blk_count}, 512'(0));
    core_lat = tab[e].lat;
    s0 = starts;
    for (int b = 0; b < tab[e].nblk; b++) begin
      send_block(blk_tab[e][b], b == tab[e].nblk - 1, tab[e].hold);
      if (tab[e].mid_start && b == tab[e].nblk - 1) begin
        @(negedge clk);
        pulse_start();
      end
    end
    while (!digest_valid && w < 400) begin
      if (tab[e].hold && (blk_ready || blk_count != 8'd1)) hold_bad = 1'b1;
      @(negedge clk);
      w++;
    end
    if (tab[e].hold) begin
      check("hold_no_reaccept", 512'(hold_bad), 512'(0));
      blk_valid = 1'b0;
    end
    check("digest_valid_seen", 512'(digest_valid), 512'(1));
    check("digest", 512'(digest), 512'(tab[e].exp));
    check("blk_count", 512'(blk_count), 512'(tab[e].nblk));
    check("core_start_pulses", 512'(starts - s0), 512'(tab[e].nblk));
    check("no_error", 512'(error), 512'(0));
    if (tab[e].ack_start) begin
      msg_start  = 1'b1;
      digest_ack = 1'b1;
      @(negedge clk);
      msg_start  = 1'b0;
      digest_ack = 1'b0;
      check("start_beats_ack", {busy, blk_ready, digest_valid}, 512'(3'b110));
    end else begin
      digest_ack = 1'b1;
      @(negedge clk);
      digest_ack = 1'b0;
      check("ack_drops_valid", {digest_valid, busy}, 512'(0));
      check("digest_retained", 512'(digest), 512'(tab[e].exp));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [511:0] abc_blk, two_b1, two_b2, rb;
    int s0, w;

    abc_blk = {32'h61626380, {14{32'h0}}, 32'h00000018};
    two_b1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
               32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
               32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
               32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    two_b2  = {{15{32'h0}}, 32'h000001c0};

    for (int i = 0; i < 7; i++)
      for (int b = 0; b < 4; b++)
        for (int k = 0; k < 16; k++) blk_tab[i][b][k*32 +: 32] = $urandom;
    blk_tab[0][0] = abc_blk;
    blk_tab[1][0] = two_b1;
    blk_tab[1][1] = two_b2;
    blk_tab[6][0] = abc_blk;

    tab[0] = '{1, 1, 0, 0, 0, ABC_D};
    tab[1] = '{2, 5, 0, 0, 0, TWO_D};
    tab[2] = '{1, int'($urandom_range(1, 12)), 0, 0, 0, '0};
    tab[3] = '{3, int'($urandom_range(3, 10)), 1, 0, 0, '0};
    tab[4] = '{4, TMO - 1, 0, 0, 0, '0};
    tab[5] = '{2, int'($urandom_range(2, 8)), 0, 0, 1, '0};
    tab[6] = '{1, 6, 0, 1, 0, ABC_D};
    for (int i = 2; i < 6; i++) tab[i].exp = sha1_ref(i);

    #1 reset = 1'b1;
    #1;
    check("reset_ctrl", {blk_ready, core_start, digest_valid, busy, error, blk_count}, 512'(0));
    check("reset_digest", 512'(digest), 512'(0));
    check("reset_core_block", core_block, 512'(0));
    check("reset_core_state", 512'(core_state), 512'(IV_TB));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int e = 0; e < 7; e++) run_msg(e);

    // Core never answers: error exactly CORE_TIMEOUT cycles after core_start.
    pulse_start();
    core_lat = 0;
    send_block(abc_blk, 1'b1, 1'b0);
    w = 0;
    while (!error && w < 300) begin @(negedge clk); w++; end
    check("timeout_error", 512'(error), 512'(1));
    check("timeout_cycles", 512'(cyc - start_cyc), 512'(TMO));
    check("timeout_idle", {busy, blk_ready, digest_valid}, 512'(0));

    // Done one cycle too late is ignored.
    pulse_start();
    check("start_clears_error", 512'(error), 512'(0));
    core_lat = TMO;
    send_block(abc_blk, 1'b1, 1'b0);
    w = 0;
    while (!error && w < 300) begin @(negedge clk); w++; end
    check("late_timeout_cycles", 512'(cyc - start_cyc), 512'(TMO));
    repeat (5) @(negedge clk);
    check("late_done_ignored", {digest_valid, error, busy}, 512'(3'b010));

    // Overflow: non-last block beyond MAX_BLOCKS.
    pulse_start();
    core_lat = 1;
    s0 = starts;
    for (int i = 0; i < MAXB; i++) begin
      for (int k = 0; k < 16; k++) rb[k*32 +: 32] = $urandom;
      send_block(rb, 1'b0, 1'b0);
    end
    check("ovf_count_max", 512'(blk_count), 512'(MAXB));
    check("ovf_no_error_yet", 512'(error), 512'(0));
    send_block(rb, 1'b0, 1'b0);
    check("ovf_error", {error, busy, blk_ready}, 512'(3'b100));
    repeat (3) @(negedge clk);
    check("ovf_not_launched", 512'(starts - s0), 512'(MAXB));
    run_msg(0);

    // Reset mid-RUN: asynchronous clear, abandoned run's done ignored.
    pulse_start();
    core_lat = 20;
    send_block(abc_blk, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("pre_reset_busy", 512'(busy), 512'(1));
    #2 reset = 1'b1;
    #1;
    check("midrun_reset_ctrl", {blk_ready, core_start, digest_valid, busy, error, blk_count}, 512'(0));
    check("midrun_reset_digest", 512'(digest), 512'(0));
    check("midrun_reset_block", core_block, 512'(0));
    check("midrun_reset_state", 512'(core_state), 512'(IV_TB));
    @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    check("stale_done_ignored", {digest_valid, busy, error}, 512'(0));
    run_msg(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
